// File: rtl/multpool_rd_sched.sv
// Read scheduler for the multiplier-pool result memories: round-robin arbitration
// of NREQ requesters onto the single bank-read / OR-mux path, with in-order response routing.
module multpool_rd_sched #(
  parameter int NREQ   = 4,
  parameter int ADDR_W = 10,
  parameter int NBITS  = 256,
  parameter int RD_LAT = 2
) (
  input  logic                   hclk,
  input  logic                   hresetn,
  input  logic                   arb_en,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  output logic [NREQ-1:0]        gnt,
  output logic                   mem_rd_en,
  output logic [ADDR_W-1:0]      mem_rd_addr,
  output logic                   mux_valid_rd,
  input  logic [3*NBITS-1:0]     mux_hrdata,
  output logic [NREQ-1:0]        rsp_valid,
  output logic [3*NBITS-1:0]     rsp_data,
  output logic                   busy
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [PTR_W-1:0]  rr_ptr;
  logic              pick_any;
  logic [PTR_W-1:0]  pick_idx;
  logic              grant;
  logic              reads_pending;
  logic [ADDR_W-1:0] addr_arr [NREQ];

  // vld_p[j] / id_p[j]: read granted j+1 cycles ago; the last stage is the response cycle
  logic [RD_LAT:0]   vld_p;
  logic [PTR_W-1:0]  id_p [RD_LAT+1];
  logic [ADDR_W-1:0] addr_p0;

  for (genvar g = 0; g < NREQ; g++) begin : g_addr_unpack
    assign addr_arr[g] = req_addr[g*ADDR_W +: ADDR_W];
  end

  always_comb begin : rr_search
    int idx;
    pick_any = 1'b0;
    pick_idx = '0;
    idx      = 0;
    for (int i = 0; i < NREQ; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!pick_any && req[PTR_W'(idx)]) begin
        pick_any = 1'b1;
        pick_idx = PTR_W'(idx);
      end
    end
  end

  // arb_en gates the grant directly so a falling arb_en wins over a pending request
  assign grant = (state_q == RUN) && arb_en && pick_any;

  always_comb begin
    gnt = '0;
    if (grant) gnt[pick_idx] = 1'b1;
  end

  // The response stage is excluded: DRAIN may retire to IDLE while the last response is out
  assign reads_pending = |vld_p[RD_LAT-1:0];

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (arb_en) state_d = RUN;
      RUN:     if (!arb_en) state_d = DRAIN;
      DRAIN: begin
        if (arb_en)              state_d = RUN;
        else if (!reads_pending) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // ---- stage p0: issue bank read; later stages carry the requester id to the response ----
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q <= IDLE;
      rr_ptr  <= '0;
      vld_p   <= '0;
      addr_p0 <= '0;
    end else begin
      state_q <= state_d;
      vld_p   <= {vld_p[RD_LAT-1:0], grant};
      if (grant) begin
        rr_ptr  <= (pick_idx == PTR_W'(NREQ-1)) ? '0 : pick_idx + 1'b1;
        addr_p0 <= addr_arr[pick_idx];
      end
    end
  end

  always_ff @(posedge hclk) begin
    id_p[0] <= pick_idx;
    for (int j = 1; j <= RD_LAT; j++) id_p[j] <= id_p[j-1];
  end

  // ---- stage p(RD_LAT-1): mux register loads; stage p(RD_LAT): response to requester ----
  assign mem_rd_en    = vld_p[0];
  assign mem_rd_addr  = addr_p0;
  assign mux_valid_rd = vld_p[RD_LAT-1];
  assign rsp_data     = mux_hrdata;
  assign busy         = (state_q != IDLE) || (|vld_p);

  always_comb begin
    rsp_valid = '0;
    if (vld_p[RD_LAT]) rsp_valid[id_p[RD_LAT]] = 1'b1;
  end

endmodule

// File: tb/tb_multpool_rd_sched.sv
// Bench for multpool_rd_sched: cycle-timeline reference model (grant history per cycle)
// checked every cycle, plus directed scenarios with hand-computed expectations.
`timescale 1ns/1ps
module tb_multpool_rd_sched;
  localparam int NREQ   = 4;
  localparam int ADDR_W = 10;
  localparam int NBITS  = 256;
  localparam int RD_LAT = 2;
  localparam int DW     = 3*NBITS;
  localparam int HMAX   = 8192;
  localparam int S_IDLE = 0, S_RUN = 1, S_DRAIN = 2;

  logic                   hclk = 1'b0;
  logic                   hresetn = 1'b0;
  logic                   arb_en = 1'b0;
  logic [NREQ-1:0]        req = '0;
  logic [NREQ*ADDR_W-1:0] req_addr = '0;
  logic [DW-1:0]          mux_hrdata = '0;
  logic [NREQ-1:0]        gnt;
  logic                   mem_rd_en;
  logic [ADDR_W-1:0]      mem_rd_addr;
  logic                   mux_valid_rd;
  logic [NREQ-1:0]        rsp_valid;
  logic [DW-1:0]          rsp_data;
  logic                   busy;

  multpool_rd_sched #(.NREQ(NREQ), .ADDR_W(ADDR_W), .NBITS(NBITS), .RD_LAT(RD_LAT)) dut (
    .hclk(hclk), .hresetn(hresetn), .arb_en(arb_en), .req(req), .req_addr(req_addr),
    .gnt(gnt), .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mux_valid_rd(mux_valid_rd),
    .mux_hrdata(mux_hrdata), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy)
  );

  always #5 hclk = ~hclk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model: scheduler mode, round-robin pointer, and the grant made in each cycle
  int                m_state;
  int                m_rr;
  bit                g_v    [HMAX];
  int                g_id   [HMAX];
  logic [ADDR_W-1:0] g_addr [HMAX];

  logic [NREQ-1:0]   obs_gnt, obs_rsp;
  logic              obs_en, obs_mv, obs_busy;
  logic [ADDR_W-1:0] obs_addr;
  logic [DW-1:0]     obs_data;
  bit                fix_data = 1'b0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic bit past_v(input int j);
    return (cyc - j >= 0) ? g_v[cyc-j] : 1'b0;
  endfunction

  function automatic logic [NREQ*ADDR_W-1:0] rand_addr();
    logic [NREQ*ADDR_W-1:0] v;
    for (int i = 0; i < NREQ; i++) v[i*ADDR_W +: ADDR_W] = ADDR_W'($urandom);
    return v;
  endfunction

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] v;
    for (int i = 0; i < DW/32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic model_clear();
    m_state = S_IDLE;
    m_rr    = 0;
    for (int i = 0; i < HMAX; i++) g_v[i] = 1'b0;
  endtask

  // Called mid-cycle: compare all outputs with the model, then advance the model one cycle
  task automatic check_cycle();
    logic [NREQ-1:0] e_gnt, e_rsp;
    int k;
    bit pend, e_busy;
    k = -1;
    e_gnt = '0;
    if (m_state == S_RUN && arb_en) begin
      for (int i = 0; i < NREQ; i++) begin
        int idx;
        idx = (m_rr + i) % NREQ;
        if (k < 0 && req[idx]) k = idx;
      end
    end
    if (k >= 0) e_gnt[k] = 1'b1;
    e_rsp = '0;
    if (past_v(RD_LAT+1)) e_rsp[g_id[cyc-RD_LAT-1]] = 1'b1;
    pend = 1'b0;
    for (int j = 1; j <= RD_LAT; j++) if (past_v(j)) pend = 1'b1;
    e_busy = (m_state != S_IDLE) || pend || past_v(RD_LAT+1);

    obs_gnt = gnt; obs_rsp = rsp_valid; obs_en = mem_rd_en; obs_mv = mux_valid_rd;
    obs_busy = busy; obs_addr = mem_rd_addr; obs_data = rsp_data;

    chk("gnt", gnt, e_gnt);
    chk("mem_rd_en", mem_rd_en, past_v(1));
    if (past_v(1)) chk("mem_rd_addr", mem_rd_addr, g_addr[cyc-1]);
    chk("mux_valid_rd", mux_valid_rd, past_v(RD_LAT));
    chk("rsp_valid", rsp_valid, e_rsp);
    if (e_rsp != '0) chk("rsp_data", rsp_data, mux_hrdata);
    chk("busy", busy, e_busy);

    if (cyc >= HMAX) begin
      $display("FAIL history_overflow cyc=%0d actual=%0d required<%0d", cyc, cyc, HMAX);
      $fatal(1, "history overflow");
    end
    g_v[cyc] = (k >= 0);
    g_id[cyc] = k;
    if (k >= 0) g_addr[cyc] = req_addr[k*ADDR_W +: ADDR_W];

    case (m_state)
      S_IDLE:  if (arb_en) m_state = S_RUN;
      S_RUN:   if (!arb_en) m_state = S_DRAIN;
      default: begin
        if (arb_en)     m_state = S_RUN;
        else if (!pend) m_state = S_IDLE;
      end
    endcase
    if (k >= 0) m_rr = (k + 1) % NREQ;
    cyc++;
  endtask

  task automatic tick(input logic [NREQ-1:0] r, input logic en, input logic [NREQ*ADDR_W-1:0] a);
    @(posedge hclk);
    #1;
    req = r;
    arb_en = en;
    req_addr = a;
    if (!fix_data) mux_hrdata = rand_data();
    #4;
    check_cycle();
  endtask

  task automatic do_reset(input int n, input logic [NREQ-1:0] r, input logic en);
    @(posedge hclk);
    #1;
    hresetn = 1'b0;
    req = r;
    arb_en = en;
    #1;
    chk("rst_gnt", gnt, '0);
    chk("rst_mem_rd_en", mem_rd_en, '0);
    chk("rst_mem_rd_addr", mem_rd_addr, '0);
    chk("rst_mux_valid_rd", mux_valid_rd, '0);
    chk("rst_rsp_valid", rsp_valid, '0);
    chk("rst_busy", busy, '0);
    model_clear();
    repeat (n) @(posedge hclk);
    #1;
    hresetn = 1'b1;
    #4;
    check_cycle();
  endtask

  initial begin
    logic [NREQ-1:0]        s1_exp [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [NREQ-1:0]        s6_exp [4] = '{4'b1000, 4'b0010, 4'b1000, 4'b0010};
    logic [NREQ*ADDR_W-1:0] a;
    logic [DW-1:0]          big;
    logic [NREQ-1:0]        r;
    logic                   en_r;
    int ng, nr, first_r, last_r, idle_at;

    model_clear();

    // Reset with everybody requesting: grants rotate 0,1,2,3,0
    do_reset(2, 4'b1111, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick(4'b1111, 1'b1, rand_addr());
      chk("s1_gnt", obs_gnt, s1_exp[i]);
      if (i > 0) chk("s1_rd_en", obs_en, 1'b1);
    end

    // Single read from requester 2 with a known address and return word
    a = rand_addr();
    a[2*ADDR_W +: ADDR_W] = 10'h3A5;
    tick(4'b0100, 1'b1, a);
    chk("s2_gnt", obs_gnt, 4'b0100);
    tick(4'b0000, 1'b1, rand_addr());
    chk("s2_rd_en", obs_en, 1'b1);
    chk("s2_rd_addr", obs_addr, 10'h3A5);
    tick(4'b0000, 1'b1, rand_addr());
    chk("s2_valid_rd", obs_mv, 1'b1);
    big = '0;
    big[DW-1 -: 16] = 16'hDEAD;
    big[15:0] = 16'hBEEF;
    fix_data = 1'b1;
    mux_hrdata = big;
    tick(4'b0000, 1'b1, rand_addr());
    chk("s2_rsp_valid", obs_rsp, 4'b0100);
    chk("s2_rsp_data", obs_data, big);
    fix_data = 1'b0;

    // Requester 0 alone for 8 cycles: full throughput, contiguous responses
    ng = 0; nr = 0; first_r = -1; last_r = -1;
    for (int i = 0; i < 11; i++) begin
      tick((i < 8) ? 4'b0001 : 4'b0000, 1'b1, rand_addr());
      if (obs_gnt == 4'b0001) ng++;
      if (obs_rsp == 4'b0001) begin
        nr++;
        if (first_r < 0) first_r = i;
        last_r = i;
      end
    end
    chk("s3_grants", ng, 8);
    chk("s3_rsps", nr, 8);
    chk("s3_contig", last_r - first_r + 1, 8);
    chk("s3_model_rr", m_rr, 1);
    tick(4'b1111, 1'b1, rand_addr());
    chk("s3_next_gnt", obs_gnt, 4'b0010);

    // Three more grants, then drop arb_en and drain
    for (int i = 0; i < 3; i++) tick(4'b1111, 1'b1, rand_addr());
    nr = 0; last_r = -1; idle_at = -1;
    for (int i = 0; i < 8; i++) begin
      tick(4'b1111, 1'b0, rand_addr());
      if (i == 0) chk("s4_nogrant", obs_gnt, 4'b0000);
      if (obs_rsp != '0) begin nr++; last_r = i; end
      if (!obs_busy && idle_at < 0) idle_at = i;
    end
    chk("s4_rsps", nr, 3);
    chk("s4_busy_fall", idle_at, last_r + 1);
    chk("s4_idle_gnt", obs_gnt, 4'b0000);

    // Reset with two reads in flight: nothing stale afterwards
    tick(4'b1111, 1'b1, rand_addr());
    tick(4'b1111, 1'b1, rand_addr());
    tick(4'b1111, 1'b1, rand_addr());
    do_reset(2, 4'b0000, 1'b0);
    nr = 0;
    for (int i = 0; i < 5; i++) begin
      tick(4'b0000, 1'b0, rand_addr());
      if (obs_rsp != '0) nr++;
    end
    chk("s5_no_stale", nr, 0);

    // rr_ptr=2 with req=1010: alternate 3,1,3,1
    tick(4'b0000, 1'b1, rand_addr());
    tick(4'b0010, 1'b1, rand_addr());
    chk("s6_setup", obs_gnt, 4'b0010);
    for (int i = 0; i < 4; i++) begin
      tick(4'b1010, 1'b1, rand_addr());
      chk("s6_gnt", obs_gnt, s6_exp[i]);
    end

    // Randomized traffic with arb_en runs and occasional resets
    en_r = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 15) == 0) en_r = ~en_r;
      if ($urandom_range(0, 3) == 0) r = NREQ'(1) << $urandom_range(0, NREQ-1);
      else                           r = NREQ'($urandom);
      if ($urandom_range(0, 299) == 0) do_reset($urandom_range(1, 3), r, en_r);
      else                             tick(r, en_r, rand_addr());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
